// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory: RISC-V funct3 codes,
// FSM state, debug view, access size and legality decode.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {INIT, RUN} state_t;

  // rsp_strb: byte lanes covered by the response currently on the bus.
  typedef struct packed {
    state_t     state;
    logic [7:0] rsp_strb;
  } dmem_dbg_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3, input int width);
    is_legal = 1'b1;
    if (funct3 == 3'b111) is_legal = 1'b0;
    if (we && funct3[2]) is_legal = 1'b0;
    if ((width == 32) && ((funct3 == F3_D) || (funct3 == F3_WU))) is_legal = 1'b0;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus of the byte-lane data memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// its response (rsp_valid for one cycle) follows exactly one cycle later and
// cannot be stalled.
interface dmem_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10
);
  localparam int BOFF = $clog2(WIDTH / 8);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [ADDRESS+BOFF-1:0] req_addr;
  logic [WIDTH-1:0]        req_wdata;
  logic                    rsp_valid;
  logic [WIDTH-1:0]        rsp_rdata;
  logic                    rsp_fault;
  logic                    init_busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, init_busy
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering. STORE=1: build the byte strobe and shift
// right-justified data into its lanes. STORE=0: extract a lane and extend it.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BOFF  = 2,
  parameter bit STORE = 1'b1
) (
  input  logic [2:0]         funct3_i,
  input  logic [BOFF-1:0]    offset_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH/8-1:0] strb_o,
  output logic [WIDTH-1:0]   data_o
);
  localparam int NB = WIDTH / 8;

  int                 nb;
  logic [NB-1:0]      mask;
  logic [WIDTH-1:0]   sh;
  logic               fill;

  always_comb begin
    nb = int'(size_bytes(funct3_i));
    if (nb > NB) nb = NB;
    for (int b = 0; b < NB; b++) mask[b] = (b < nb);
    strb_o = mask << offset_i;
    sh     = data_i >> (8 * int'(offset_i));
    fill   = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == nb - 1) fill = sh[8*b+7];
    end
    fill = fill & ~funct3_i[2];
    if (STORE) begin
      data_o = data_i << (8 * int'(offset_i));
    end else begin
      for (int i = 0; i < WIDTH; i++) data_o[i] = (i < 8 * nb) ? sh[i] : fill;
    end
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory for RV32/RV64 sub-word loads/stores, 1-cycle read,
// self-clearing after reset. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10
) (
  input  logic      clk,
  input  logic      reset,
  dmem_if.slave     bus,
  output dmem_dbg_t dbg_o
);
  localparam int BOFF  = $clog2(WIDTH / 8);
  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 2 ** ADDRESS;

  state_t              state_q;
  logic [ADDRESS-1:0]  cnt_q;
  logic                init_busy_q;
  logic                rsp_valid_q;
  logic                rsp_fault_q;
  logic                rsp_zero_q;
  logic [2:0]          ld_f3_q;
  logic [BOFF-1:0]     ld_off_q;
  logic [WIDTH-1:0]    rd_word_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                acc;
  logic                legal;
  logic                ok;
  logic                wr_en;
  logic [ADDRESS-1:0]  waddr;
  logic [BOFF-1:0]     size_m1;
  logic [BOFF-1:0]     eff_off;
  logic [NB-1:0]       st_strb;
  logic [WIDTH-1:0]    st_data;
  logic [NB-1:0]       ld_strb;
  logic [WIDTH-1:0]    ld_data;

  always_comb begin
    waddr   = bus.req_addr[ADDRESS+BOFF-1:BOFF];
    size_m1 = BOFF'(size_bytes(bus.req_funct3) - 4'd1);
    legal   = is_legal(bus.req_we, bus.req_funct3, WIDTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    eff_off = bus.req_addr[BOFF-1:0];
    ok      = legal && ((eff_off & size_m1) == '0);
`else
    eff_off = bus.req_addr[BOFF-1:0] & ~size_m1;
    ok      = legal;
`endif
    acc   = bus.req_valid && (state_q == RUN);
    wr_en = acc && bus.req_we && ok;
  end

  dmem_lane_align #(.WIDTH(WIDTH), .BOFF(BOFF), .STORE(1'b1)) u_st_align (
    .funct3_i (bus.req_funct3),
    .offset_i (eff_off),
    .data_i   (bus.req_wdata),
    .strb_o   (st_strb),
    .data_o   (st_data)
  );

  dmem_lane_align #(.WIDTH(WIDTH), .BOFF(BOFF), .STORE(1'b0)) u_ld_align (
    .funct3_i (ld_f3_q),
    .offset_i (ld_off_q),
    .data_i   (rd_word_q),
    .strb_o   (ld_strb),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_zero_q  <= 1'b1;
      ld_f3_q     <= F3_W;
      ld_off_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
          rsp_zero_q  <= 1'b1;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == ADDRESS'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_busy_q <= 1'b0;
          end
        end
        RUN: begin
          rsp_valid_q <= acc;
          rsp_fault_q <= acc && !ok;
          rsp_zero_q  <= !acc || bus.req_we || !ok;
          if (acc) begin
            ld_f3_q  <= bus.req_funct3;
            ld_off_q <= eff_off;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // The array has no reset: the INIT walk clears it, and reset forces INIT.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < NB; b++) begin
          if (st_strb[b]) mem_q[waddr][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
      if (acc) rd_word_q <= mem_q[waddr];
    end
  end

  assign bus.req_ready   = (state_q == RUN);
  assign bus.init_busy   = init_busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_fault   = rsp_fault_q;
  assign bus.rsp_rdata   = rsp_zero_q ? '0 : ld_data;
  assign dbg_o.state     = state_q;
  assign dbg_o.rsp_strb  = 8'(ld_strb);

endmodule
